alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single ALU between two requesters: port 0 (pipeline EX stage) and port 1
//  (secondary issuer, e.g. address generation). Round-robin arbitration, registered ALU
//  operands held for ALU_LATENCY cycles, and a one-cycle result pulse back to the owner.
//  Sits between the requesters and the ALU; consumes the ALU's ALU_stall output.
// PARAMETERS
//  OPERAND_SIZE  32  operand/result width
//  OP_SIZE       1   ALU_op width
//  ALU_LATENCY   1   cycles ALU inputs are held before the result is captured (1..8)
// PORTS
//  clk            in   1             clock, all state on rising edge
//  reset_n        in   1             asynchronous, active-low reset
//  req0_valid     in   1             port 0 request
//  req0_op        in   OP_SIZE       port 0 operation
//  req0_operand1  in   OPERAND_SIZE  port 0 operand 1
//  req0_operand2  in   OPERAND_SIZE  port 0 operand 2
//  req0_stall     out  1             request not accepted this cycle; hold inputs
//  req0_res_valid out  1             one-cycle result pulse for port 0
//  req0_result    out  OPERAND_SIZE  last port 0 result (held)
//  req1_*         --   --            identical set for port 1
//  ALU_op         out  OP_SIZE       registered op to ALU
//  ALU_operand1   out  OPERAND_SIZE  registered operand 1 to ALU
//  ALU_operand2   out  OPERAND_SIZE  registered operand 2 to ALU
//  ALU_in_use     out  1             ALU owns a live operation
//  ALU_result     in   OPERAND_SIZE  ALU combinational result
//  ALU_stall      in   1             downstream freeze (ALU_in_use && stall_in)
// BEHAVIOUR
//  - Reset: state IDLE, cnt 0, owner 0, last_grant 1 (port 0 wins first tie), ALU_op/
//    operands 0, ALU_in_use 0, res_valid 0, results 0. reqN_stall = reqN_valid while reset.
//  - States: IDLE, BUSY. can_accept = IDLE | (BUSY & cnt==1 & !ALU_stall).
//  - Grant (comb): only one valid -> that port; both valid -> port != last_grant.
//    reqN_stall = reqN_valid & !(can_accept & grantN). Never stalls an idle port.
//  - Accept at edge: latch op/operands of granted port, owner<=N, last_grant<=N,
//    cnt<=ALU_LATENCY, state<=BUSY. ALU_in_use = (state==BUSY).
//  - BUSY: ALU_stall=1 -> cnt, regs, state frozen, no capture, no accept. Else cnt-1;
//    at cnt==1 capture ALU_result into reqOWNER_result, pulse reqOWNER_res_valid next
//    cycle; go IDLE unless a new accept in same cycle (back-to-back, no bubble).
//  - Latency accept-edge -> res_valid: ALU_LATENCY+1 cycles w/o stalls; each stall
//    cycle adds one. Throughput: one op per ALU_LATENCY cycles.
//  - Results of the other port untouched; res_valid never both high.
//  - Async reset mid-BUSY: op discarded, no res_valid pulse, back to IDLE.
//  - Requester drops valid while stalled: legal, no effect.
// STRUCTURE
//  - Package alu_sched_pkg: state enum {IDLE, BUSY}, PORT0/PORT1 owner constants,
//    cnt width localparam $clog2(ALU_LATENCY+1).
//  - Sub-module rr_arbiter2: 2-way round-robin (valid0, valid1, last_grant, enable ->
//    grant0, grant1). Rest (FSM, counter, operand/result regs) in this module.
// TESTING
//  - LAT=1, req0 op=1 5/3, req1 idle -> req0_stall 0, ALU_operand1=5 next cycle,
//    req0_res_valid pulses 2 cycles after accept with ALU value.
//  - Both valid every cycle from reset, LAT=1 -> grants 0,1,0,1; stalled port sees
//    stall=1; each result routed only to its owner.
//  - LAT=3, back-to-back req0 -> accepts every 3 cycles, ALU_in_use continuously high,
//    no IDLE cycle between ops.
//  - ALU_stall high 2 cycles mid-op (LAT=3) -> res_valid delayed 2 cycles, ALU inputs
//    stable, both requesters stalled, no new accept.
//  - reset_n low while BUSY -> ALU_in_use 0 immediately, no res_valid, next tie grants
//    port 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU issue arbiter.
package alu_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Counter must hold ALU_LATENCY itself.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Requester and ALU signal bundle for the ALU issue arbiter.
interface alu_issue_arbiter_if #(
  parameter int unsigned OPERAND_SIZE = 32,
  parameter int unsigned OP_SIZE      = 1
);
  logic                    req0_valid;
  logic [OP_SIZE-1:0]      req0_op;
  logic [OPERAND_SIZE-1:0] req0_operand1;
  logic [OPERAND_SIZE-1:0] req0_operand2;
  logic                    req0_stall;
  logic                    req0_res_valid;
  logic [OPERAND_SIZE-1:0] req0_result;

  logic                    req1_valid;
  logic [OP_SIZE-1:0]      req1_op;
  logic [OPERAND_SIZE-1:0] req1_operand1;
  logic [OPERAND_SIZE-1:0] req1_operand2;
  logic                    req1_stall;
  logic                    req1_res_valid;
  logic [OPERAND_SIZE-1:0] req1_result;

  logic [OP_SIZE-1:0]      ALU_op;
  logic [OPERAND_SIZE-1:0] ALU_operand1;
  logic [OPERAND_SIZE-1:0] ALU_operand2;
  logic                    ALU_in_use;
  logic [OPERAND_SIZE-1:0] ALU_result;
  logic                    ALU_stall;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_operand1, req0_operand2,
    output req0_stall, req0_res_valid, req0_result,
    input  req1_valid, req1_op, req1_operand1, req1_operand2,
    output req1_stall, req1_res_valid, req1_result,
    output ALU_op, ALU_operand1, ALU_operand2, ALU_in_use,
    input  ALU_result, ALU_stall
  );

  // Requesters plus ALU side.
  modport master (
    output req0_valid, req0_op, req0_operand1, req0_operand2,
    input  req0_stall, req0_res_valid, req0_result,
    output req1_valid, req1_op, req1_operand1, req1_operand2,
    input  req1_stall, req1_res_valid, req1_result,
    input  ALU_op, ALU_operand1, ALU_operand2, ALU_in_use,
    output ALU_result, ALU_stall
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port that did not win last time wins.
module rr_arbiter2
  import alu_sched_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  input  logic i_enable,
  output logic o_grant0_c,
  output logic o_grant1_c
);

  logic w_pick1;

  always_comb begin
    w_pick1 = 1'b0;
    if (i_valid0 && i_valid1) begin
      w_pick1 = (i_last_grant == PORT0);
    end else begin
      w_pick1 = i_valid1;
    end
  end

  assign o_grant0_c = i_enable && i_valid0 && !w_pick1;
  assign o_grant1_c = i_enable && i_valid1 && w_pick1;

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between two requesters: round-robin issue, operands held for
// ALU_LATENCY cycles, result captured and pulsed back to the owning port.
module alu_issue_arbiter
  import alu_sched_pkg::*;
#(
  parameter int unsigned OPERAND_SIZE = 32,
  parameter int unsigned OP_SIZE      = 1,
  parameter int unsigned ALU_LATENCY  = 1
) (
  input logic          clk,
  input logic          reset_n,
  alu_issue_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W    = cnt_width(ALU_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY);

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_owner, w_owner_nxt;
  logic                    r_last_grant, w_last_grant_nxt;
  logic [OP_SIZE-1:0]      r_op, w_op_nxt;
  logic [OPERAND_SIZE-1:0] r_opnd1, w_opnd1_nxt;
  logic [OPERAND_SIZE-1:0] r_opnd2, w_opnd2_nxt;
  logic [OPERAND_SIZE-1:0] r_res0, w_res0_nxt;
  logic [OPERAND_SIZE-1:0] r_res1, w_res1_nxt;
  logic                    r_rv0, w_rv0_nxt;
  logic                    r_rv1, w_rv1_nxt;

  logic w_last_cycle;
  logic w_can_accept;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  // A new op may issue in the same cycle the current one completes.
  assign w_last_cycle = (r_state == BUSY) && (r_cnt == CNT_ONE) && !bus.ALU_stall;
  assign w_can_accept = (r_state == IDLE) || w_last_cycle;
  assign w_accept     = w_grant0 || w_grant1;

  rr_arbiter2 u_rr (
    .i_valid0     (bus.req0_valid),
    .i_valid1     (bus.req1_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_can_accept),
    .o_grant0_c   (w_grant0),
    .o_grant1_c   (w_grant1)
  );

  // Held in reset, every valid request sees stall.
  assign bus.req0_stall = bus.req0_valid && !(w_grant0 && reset_n);
  assign bus.req1_stall = bus.req1_valid && !(w_grant1 && reset_n);

  assign bus.ALU_op         = r_op;
  assign bus.ALU_operand1   = r_opnd1;
  assign bus.ALU_operand2   = r_opnd2;
  assign bus.ALU_in_use     = (r_state == BUSY);
  assign bus.req0_res_valid = r_rv0;
  assign bus.req1_res_valid = r_rv1;
  assign bus.req0_result    = r_res0;
  assign bus.req1_result    = r_res1;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_op_nxt         = r_op;
    w_opnd1_nxt      = r_opnd1;
    w_opnd2_nxt      = r_opnd2;
    w_res0_nxt       = r_res0;
    w_res1_nxt       = r_res1;
    w_rv0_nxt        = 1'b0;
    w_rv1_nxt        = 1'b0;

    if ((r_state == BUSY) && !bus.ALU_stall) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
      if (r_cnt == CNT_ONE) begin
        w_state_nxt = IDLE;
        if (r_owner == PORT1) begin
          w_res1_nxt = bus.ALU_result;
          w_rv1_nxt  = 1'b1;
        end else begin
          w_res0_nxt = bus.ALU_result;
          w_rv0_nxt  = 1'b1;
        end
      end
    end

    if (w_accept) begin
      w_state_nxt      = BUSY;
      w_cnt_nxt        = CNT_INIT;
      w_owner_nxt      = w_grant1;
      w_last_grant_nxt = w_grant1;
      w_op_nxt         = w_grant1 ? bus.req1_op       : bus.req0_op;
      w_opnd1_nxt      = w_grant1 ? bus.req1_operand1 : bus.req0_operand1;
      w_opnd2_nxt      = w_grant1 ? bus.req1_operand2 : bus.req0_operand2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= PORT0;
      r_last_grant <= PORT1;
      r_op         <= '0;
      r_opnd1      <= '0;
      r_opnd2      <= '0;
      r_res0       <= '0;
      r_res1       <= '0;
      r_rv0        <= 1'b0;
      r_rv1        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_op         <= w_op_nxt;
      r_opnd1      <= w_opnd1_nxt;
      r_opnd2      <= w_opnd2_nxt;
      r_res0       <= w_res0_nxt;
      r_res1       <= w_res1_nxt;
      r_rv0        <= w_rv0_nxt;
      r_rv1        <= w_rv1_nxt;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: two instances (latency 1 and 3) checked every
// cycle against a cycle-count model, plus hand-computed spot values.
module tb_alu_issue_arbiter;

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 1;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.OPERAND_SIZE(W), .OP_SIZE(OPW)) bus_a ();
  alu_issue_arbiter_if #(.OPERAND_SIZE(W), .OP_SIZE(OPW)) bus_b ();

  alu_issue_arbiter #(.OPERAND_SIZE(W), .OP_SIZE(OPW), .ALU_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  alu_issue_arbiter #(.OPERAND_SIZE(W), .OP_SIZE(OPW), .ALU_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  // ALU stand-in: op 1 subtracts, op 0 adds.
  function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    return (op == 1'b1) ? (a - b) : (a + b);
  endfunction

  assign bus_a.ALU_result = alu_f(bus_a.ALU_op, bus_a.ALU_operand1, bus_a.ALU_operand2);
  assign bus_b.ALU_result = alu_f(bus_b.ALU_op, bus_b.ALU_operand1, bus_b.ALU_operand2);

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  typedef struct packed {
    logic [1:0]     v;
    logic [OPW-1:0] op0, op1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           stall_in;
    logic [1:0]     stall, rv;
    logic [W-1:0]   res0, res1;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   o1, o2;
    logic           in_use;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: each instance is either free or holding one op until cycle m_end.
  bit             m_busy [2];
  int             m_end  [2];
  int             m_port [2];
  int             m_last [2];
  logic [OPW-1:0] m_op   [2];
  logic [W-1:0]   m_a    [2];
  logic [W-1:0]   m_b    [2];
  bit             m_rv   [2];
  int             m_rvp  [2];
  logic [W-1:0]   m_res  [2][2];

  task automatic chk(input string nm, input int k, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic sample(input int k, output obs_t o);
    if (k == 0) begin
      o.v = {bus_a.req1_valid, bus_a.req0_valid};
      o.op0 = bus_a.req0_op; o.a0 = bus_a.req0_operand1; o.b0 = bus_a.req0_operand2;
      o.op1 = bus_a.req1_op; o.a1 = bus_a.req1_operand1; o.b1 = bus_a.req1_operand2;
      o.stall_in = bus_a.ALU_stall;
      o.stall = {bus_a.req1_stall, bus_a.req0_stall};
      o.rv = {bus_a.req1_res_valid, bus_a.req0_res_valid};
      o.res0 = bus_a.req0_result; o.res1 = bus_a.req1_result;
      o.alu_op = bus_a.ALU_op; o.o1 = bus_a.ALU_operand1; o.o2 = bus_a.ALU_operand2;
      o.in_use = bus_a.ALU_in_use;
    end else begin
      o.v = {bus_b.req1_valid, bus_b.req0_valid};
      o.op0 = bus_b.req0_op; o.a0 = bus_b.req0_operand1; o.b0 = bus_b.req0_operand2;
      o.op1 = bus_b.req1_op; o.a1 = bus_b.req1_operand1; o.b1 = bus_b.req1_operand2;
      o.stall_in = bus_b.ALU_stall;
      o.stall = {bus_b.req1_stall, bus_b.req0_stall};
      o.rv = {bus_b.req1_res_valid, bus_b.req0_res_valid};
      o.res0 = bus_b.req0_result; o.res1 = bus_b.req1_result;
      o.alu_op = bus_b.ALU_op; o.o1 = bus_b.ALU_operand1; o.o2 = bus_b.ALU_operand2;
      o.in_use = bus_b.ALU_in_use;
    end
  endtask

  task automatic set_req(input int k, input int p, input logic v, input logic [OPW-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (k == 0 && p == 0) begin
      bus_a.req0_valid = v; bus_a.req0_op = op; bus_a.req0_operand1 = a; bus_a.req0_operand2 = b;
    end else if (k == 0) begin
      bus_a.req1_valid = v; bus_a.req1_op = op; bus_a.req1_operand1 = a; bus_a.req1_operand2 = b;
    end else if (p == 0) begin
      bus_b.req0_valid = v; bus_b.req0_op = op; bus_b.req0_operand1 = a; bus_b.req0_operand2 = b;
    end else begin
      bus_b.req1_valid = v; bus_b.req1_op = op; bus_b.req1_operand1 = a; bus_b.req1_operand2 = b;
    end
  endtask

  task automatic set_stall(input int k, input logic s);
    if (k == 0) bus_a.ALU_stall = s;
    else        bus_b.ALU_stall = s;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(k, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      set_stall(k, 1'b0);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 1'b0; m_end[k] = 0; m_port[k] = 0; m_last[k] = 1;
    m_rv[k] = 1'b0; m_rvp[k] = 0; m_res[k][0] = '0; m_res[k][1] = '0;
  endtask

  // Compare both instances against the model, then advance the model across the next edge.
  task automatic check_cycle();
    obs_t       o;
    int         g;
    bit         last_c;
    bit         can;
    logic [1:0] es;
    logic [1:0] erv;
    for (int k = 0; k < 2; k++) begin
      sample(k, o);
      if (!reset_n) begin
        chk("rst_stall", k, 32'(o.stall), 32'(o.v));
        chk("rst_in_use", k, 32'(o.in_use), 32'd0);
        chk("rst_res_valid", k, 32'(o.rv), 32'd0);
        chk("rst_result0", k, o.res0, 32'd0);
        chk("rst_result1", k, o.res1, 32'd0);
        model_reset(k);
        continue;
      end
      erv = 2'b00;
      if (m_rv[k]) erv[m_rvp[k]] = 1'b1;
      chk("in_use", k, 32'(o.in_use), 32'(m_busy[k]));
      chk("res_valid", k, 32'(o.rv), 32'(erv));
      chk("result0", k, o.res0, m_res[k][0]);
      chk("result1", k, o.res1, m_res[k][1]);
      if (m_busy[k]) begin
        chk("alu_op", k, 32'(o.alu_op), 32'(m_op[k]));
        chk("alu_operand1", k, o.o1, m_a[k]);
        chk("alu_operand2", k, o.o2, m_b[k]);
      end
      last_c = m_busy[k] && (m_end[k] == cyc) && !o.stall_in;
      can    = !m_busy[k] || last_c;
      g = -1;
      if (can) begin
        if (o.v == 2'b11) g = (m_last[k] == 0) ? 1 : 0;
        else if (o.v[0])  g = 0;
        else if (o.v[1])  g = 1;
      end
      es = o.v;
      if (g >= 0) es[g] = 1'b0;
      chk("stall", k, 32'(o.stall), 32'(es));

      m_rv[k] = 1'b0;
      if (m_busy[k] && o.stall_in) m_end[k]++;
      if (last_c) begin
        m_rv[k]  = 1'b1;
        m_rvp[k] = m_port[k];
        m_res[k][m_port[k]] = alu_f(m_op[k], m_a[k], m_b[k]);
        m_busy[k] = 1'b0;
      end
      if (g >= 0) begin
        m_busy[k] = 1'b1;
        m_port[k] = g;
        m_last[k] = g;
        m_op[k]   = (g == 1) ? o.op1 : o.op0;
        m_a[k]    = (g == 1) ? o.a1  : o.a0;
        m_b[k]    = (g == 1) ? o.b1  : o.b0;
        m_end[k]  = cyc + lat_of(k);
      end
    end
    cyc++;
  endtask

  task automatic half();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic rest();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    half();
    rest();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    obs_t o;
    reset_n = 1'b0;
    clear_all();
    set_req(0, 0, 1'b1, 1'b0, 32'd1, 32'd1);
    set_req(0, 1, 1'b1, 1'b0, 32'd1, 32'd1);
    set_req(1, 0, 1'b1, 1'b0, 32'd1, 32'd1);
    step();
    step();
    clear_all();
    reset_n = 1'b1;
    step();

    // Single request on the latency-1 instance.
    set_req(0, 0, 1'b1, 1'b1, 32'd5, 32'd3);
    half(); sample(0, o);
    chk("t1_stall0", 0, 32'(o.stall[0]), 32'd0);
    rest();
    set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    half(); sample(0, o);
    chk("t1_operand1", 0, o.o1, 32'd5);
    chk("t1_in_use", 0, 32'(o.in_use), 32'd1);
    chk("t1_rv_early", 0, 32'(o.rv), 32'd0);
    rest();
    half(); sample(0, o);
    chk("t1_rv", 0, 32'(o.rv), 32'd1);
    chk("t1_result", 0, o.res0, 32'd2);
    rest();
    half(); sample(0, o);
    chk("t1_rv_drop", 0, 32'(o.rv), 32'd0);
    chk("t1_result_hold", 0, o.res0, 32'd2);
    rest();

    // Both ports valid every cycle from reset: grants alternate 0,1,0,1.
    pulse_reset();
    set_req(0, 0, 1'b1, 1'b0, 32'd7, 32'd9);
    set_req(0, 1, 1'b1, 1'b1, 32'd50, 32'd8);
    for (int i = 0; i < 6; i++) begin
      half(); sample(0, o);
      chk("t2_stall", 0, 32'(o.stall), (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i >= 2) begin
        chk("t2_rv", 0, 32'(o.rv), (i % 2 == 0) ? 32'd1 : 32'd2);
        chk("t2_result0", 0, o.res0, 32'd16);
      end
      if (i >= 3) chk("t2_result1", 0, o.res1, 32'd42);
      rest();
    end
    clear_all();
    repeat (3) step();

    // Back-to-back port 0 ops on the latency-3 instance.
    set_req(1, 0, 1'b1, 1'b0, 32'd1, 32'd2);
    for (int j = 0; j < 14; j++) begin
      half(); sample(1, o);
      if (j <= 9) chk("t3_stall0", 1, 32'(o.stall[0]), (j % 3 == 0) ? 32'd0 : 32'd1);
      if (j >= 1 && j <= 12) chk("t3_in_use", 1, 32'(o.in_use), 32'd1);
      if (j >= 4 && j % 3 == 1) begin
        chk("t3_rv", 1, 32'(o.rv), 32'd1);
        chk("t3_result", 1, o.res0, 32'(((j - 4) / 3) * 10 + 3));
      end
      rest();
      if (j % 3 == 0 && j < 9) set_req(1, 0, 1'b1, 1'b0, 32'((j / 3 + 1) * 10 + 1), 32'd2);
      if (j == 9) set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    // Two-cycle ALU freeze mid-op on the latency-3 instance.
    set_req(1, 0, 1'b1, 1'b1, 32'd20, 32'd5);
    for (int j = 0; j < 14; j++) begin
      half(); sample(1, o);
      if (j == 0) chk("t4_accept", 1, 32'(o.stall), 32'd0);
      if (j == 2 || j == 3) begin
        chk("t4_stall_both", 1, 32'(o.stall), 32'd3);
        chk("t4_operand1", 1, o.o1, 32'd20);
        chk("t4_in_use", 1, 32'(o.in_use), 32'd1);
      end
      if (j == 4) chk("t4_rv_delayed", 1, 32'(o.rv), 32'd0);
      if (j == 5) chk("t4_rr_grant1", 1, 32'(o.stall), 32'd1);
      if (j == 6) begin
        chk("t4_rv0", 1, 32'(o.rv), 32'd1);
        chk("t4_result0", 1, o.res0, 32'd15);
      end
      if (j == 9) begin
        chk("t4_rv1", 1, 32'(o.rv), 32'd2);
        chk("t4_result1", 1, o.res1, 32'd10);
      end
      if (j == 12) chk("t4_result0b", 1, o.res0, 32'd101);
      rest();
      if (j == 0) begin
        set_req(1, 0, 1'b1, 1'b0, 32'd100, 32'd1);
        set_req(1, 1, 1'b1, 1'b0, 32'd9, 32'd1);
      end
      if (j == 5) set_req(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      if (j == 8) set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_stall(1, (j + 1 == 2) || (j + 1 == 3));
    end

    // Reset while the latency-3 instance is busy.
    set_req(1, 0, 1'b1, 1'b0, 32'd40, 32'd2);
    half(); sample(1, o);
    chk("t5_accept", 1, 32'(o.stall), 32'd0);
    rest();
    set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    half(); sample(1, o);
    chk("t5_busy", 1, 32'(o.in_use), 32'd1);
    rest();
    reset_n = 1'b0;
    half(); sample(1, o);
    chk("t5_rst_in_use", 1, 32'(o.in_use), 32'd0);
    rest();
    reset_n = 1'b1;
    for (int j = 3; j < 6; j++) begin
      half(); sample(1, o);
      chk("t5_no_rv", 1, 32'(o.rv), 32'd0);
      chk("t5_result0", 1, o.res0, 32'd0);
      rest();
    end
    set_req(1, 0, 1'b1, 1'b0, 32'd1, 32'd1);
    set_req(1, 1, 1'b1, 1'b0, 32'd2, 32'd2);
    half(); sample(1, o);
    chk("t5_tie_port0", 1, 32'(o.stall), 32'd2);
    rest();
    clear_all();
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
